iddr_delay_cal: RTL and testbench
=================================

IDDR_DELAY_CAL -- requirements
Module: iddr_delay_cal

Interface
REQ-001 Parameter WIDTH, default 1: number of IDDR lanes sharing one delay setting.
REQ-002 Parameter VTC_WAIT, default 16: cycles between en_vtc deassert and the first load.
REQ-003 Parameter SETTLE_CYCLES, default 16: cycles after each load before sampling starts.
REQ-004 Parameter SAMPLE_CYCLES, default 64: compare cycles per tap.
REQ-005 Parameter MIN_EYE, default 8: minimum passing run, in taps, to declare lock.
REQ-006 Port clk  in  1: sole clock; all logic on its rising edge.
REQ-007 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-008 Port start  in  1: single-cycle pulse requesting a calibration run.
REQ-009 Port q1, q2  in  WIDTH each: IDDR rising- and falling-edge samples.
REQ-010 Port dly_load  out  1: single-cycle load strobe to the delay line.
REQ-011 Port dly_cnt_value  out  9: tap value presented with dly_load.
REQ-012 Port dly_en_vtc  out  1: VT-compensation enable to the delay line.
REQ-013 Port busy, done, locked, error  out  1 each: status flags.
REQ-014 Port eye_center, eye_width  out  9 and 10: result in taps.

Function
REQ-015 The training pattern SHALL be q1 all-ones and q2 all-zeros on every lane. A tap passes only if every lane matches on every cycle of the SAMPLE_CYCLES window.
REQ-016 The FSM SHALL be IDLE -> VTC_OFF -> LOAD -> SETTLE -> SAMPLE -> EVAL, then back to LOAD until tap 511, then CENTER -> VTC_ON -> IDLE.
REQ-017 IDLE: on start, assert busy, clear done/locked/error, set tap=0, drop dly_en_vtc, enter VTC_OFF.
REQ-018 VTC_OFF: wait exactly VTC_WAIT cycles, then go to LOAD.
REQ-019 LOAD: assert dly_load for one cycle with dly_cnt_value=tap, then go to SETTLE.
REQ-020 SETTLE: wait SETTLE_CYCLES; SAMPLE: compare for SAMPLE_CYCLES; EVAL: one cycle.
REQ-021 EVAL: on pass, if no run is open, set run_start=tap; increment run_len. On fail, close the run.
REQ-022 A closed run SHALL replace the best run only if run_len > best_len, strictly, so the first of equal runs is kept. Reaching tap 511 SHALL close any open run.
REQ-023 EVAL: if tap<511, increment tap and go to LOAD; otherwise go to CENTER.
REQ-024 CENTER: if best_len >= MIN_EYE, set eye_center = best_start + (best_len>>1) and eye_width = best_len, pulse dly_load with eye_center, and set locked.
REQ-025 CENTER: otherwise set eye_center=0 and eye_width=best_len, pulse dly_load with 0, and set error.
REQ-026 The center arithmetic SHALL be 10-bit internally; the 9-bit result cannot overflow because best_start + best_len <= 512.
REQ-027 VTC_ON: reassert dly_en_vtc, deassert busy, and pulse done for one cycle.
REQ-028 locked/error SHALL hold until the next start.
REQ-029 start while busy SHALL be ignored.
REQ-030 Total latency SHALL be VTC_WAIT + 512*(SETTLE_CYCLES+SAMPLE_CYCLES+2) + 2 cycles from start to done.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE at any point, including mid-sweep.
REQ-032 Reset values: dly_en_vtc=1, dly_load=0, dly_cnt_value=0, busy/done/locked/error=0, eye_center=0, eye_width=0; all run/best trackers cleared.

Structure
REQ-033 A shared package iddr_cal_pkg SHALL hold the FSM state encoding, TAP_BITS=9 and TAP_MAX=511.
REQ-034 One sub-module, iddr_cal_window_tracker, SHALL hold run/best tracking and the center computation. The FSM and compare counters stay in the top level.

Verification
REQ-035 All taps pass -> eye_width=512, eye_center=256, locked=1, final dly_load value 256.
REQ-036 Taps 100..199 pass -> eye_width=100, eye_center=150, locked=1.
REQ-037 Runs 10..39 and 300..349 pass -> eye_center=325, eye_width=50. Runs 10..59 and 300..349 (equal length) -> eye_center=35.
REQ-038 Taps 400..511 pass (run open at end) -> eye_width=112, eye_center=456. Only taps 0..4 pass -> error=1, eye_center=0, eye_width=5.
REQ-039 Single-lane mismatch for 1 cycle at tap 200 inside 150..249 -> two runs, 150..199 (50) and 201..249 (49), giving eye_center=175.
REQ-040 rst_n low at tap 300 -> outputs at reset values within the same cycle; a new start runs a full sweep, and start pulses during busy cause no restart.

Source files
------------

// File: rtl/iddr_cal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iddr_cal_pkg : shared tap widths, FSM encoding and eye-center helper        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package iddr_cal_pkg;

  localparam int TAP_BITS = 9;
  localparam int LEN_BITS = TAP_BITS + 1;
  localparam logic [TAP_BITS-1:0] TAP_MAX = 9'd511;

  typedef logic [TAP_BITS-1:0] tap_t;
  typedef logic [LEN_BITS-1:0] len_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_VTC_OFF = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_SAMPLE  = 3'd4;
  localparam logic [2:0] ST_EVAL    = 3'd5;
  localparam logic [2:0] ST_CENTER  = 3'd6;
  localparam logic [2:0] ST_VTC_ON  = 3'd7;

  // start + len never exceeds 512, so the truncated 10-bit sum is exact
  function automatic tap_t eye_mid(input tap_t start, input len_t len);
    len_t sum;
    sum = {1'b0, start} + (len >> 1);
    return sum[TAP_BITS-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/iddr_delay_cal_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iddr_delay_cal_if : request, IDDR sample, delay-line and status bundle     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface iddr_delay_cal_if #(
  parameter int WIDTH = 1
);
  import iddr_cal_pkg::*;

  logic             start;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic             dly_load;
  tap_t             dly_cnt_value;
  logic             dly_en_vtc;
  logic             busy;
  logic             done;
  logic             locked;
  logic             error;
  tap_t             eye_center;
  len_t             eye_width;

  modport master (
    output start, q1, q2,
    input  dly_load, dly_cnt_value, dly_en_vtc,
    input  busy, done, locked, error, eye_center, eye_width
  );

  modport slave (
    input  start, q1, q2,
    output dly_load, dly_cnt_value, dly_en_vtc,
    output busy, done, locked, error, eye_center, eye_width
  );

endinterface
`default_nettype wire

// File: rtl/iddr_cal_window_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iddr_cal_window_tracker : longest passing tap run and its center           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iddr_cal_window_tracker
  import iddr_cal_pkg::*;
#(
  parameter int MIN_EYE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic eval,
  input  logic pass,
  input  tap_t tap,
  input  logic last,
  output tap_t eye_center,
  output len_t eye_width,
  output logic eye_ok
);

  logic r_run_open;
  tap_t r_run_start;
  len_t r_run_len;
  tap_t r_best_start;
  len_t r_best_len;

  tap_t w_start_nxt;
  len_t w_len_nxt;
  logic w_close;

  always_comb begin
    w_start_nxt = r_run_start;
    w_len_nxt   = r_run_len;
    if (pass) begin
      if (!r_run_open) begin
        w_start_nxt = tap;
        w_len_nxt   = len_t'(1);
      end else begin
        w_len_nxt   = r_run_len + 1'b1;
      end
    end
  end

  // the last tap closes an open run so an eye touching tap 511 still counts
  assign w_close = !pass || last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_open   <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (clr) begin
      r_run_open   <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (eval) begin
      if (w_close) begin
        if (w_len_nxt > r_best_len) begin
          r_best_start <= w_start_nxt;
          r_best_len   <= w_len_nxt;
        end
        r_run_open <= 1'b0;
        r_run_len  <= '0;
      end else begin
        r_run_open  <= 1'b1;
        r_run_start <= w_start_nxt;
        r_run_len   <= w_len_nxt;
      end
    end
  end

  assign eye_center = eye_mid(r_best_start, r_best_len);
  assign eye_width  = r_best_len;
  assign eye_ok     = (r_best_len >= len_t'(MIN_EYE));

endmodule
`default_nettype wire

// File: rtl/iddr_delay_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iddr_delay_cal : sweeps all delay taps, finds the widest eye, centers it   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iddr_delay_cal
  import iddr_cal_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int VTC_WAIT      = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MIN_EYE       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  iddr_delay_cal_if.slave   bus
);

  localparam int c_CNT_MAX =
    (VTC_WAIT > SETTLE_CYCLES) ?
      ((VTC_WAIT > SAMPLE_CYCLES) ? VTC_WAIT : SAMPLE_CYCLES) :
      ((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_VTC_LAST    = c_CNT_W'(VTC_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_CYCLES - 1);

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  tap_t               r_tap;
  logic               r_ok;
  logic               r_load;
  tap_t               r_cnt_value;
  logic               r_en_vtc;
  logic               r_busy;
  logic               r_done;
  logic               r_locked;
  logic               r_error;
  tap_t               r_eye_center;
  len_t               r_eye_width;

  logic w_match;
  logic w_clr;
  logic w_eval;
  tap_t w_center;
  len_t w_width;
  logic w_eye_ok;

  // training pattern: every lane high on the rising sample, low on the falling
  assign w_match = (bus.q1 == {WIDTH{1'b1}}) && (bus.q2 == {WIDTH{1'b0}});
  assign w_clr   = (r_state == ST_IDLE) && bus.start;
  assign w_eval  = (r_state == ST_EVAL);

  iddr_cal_window_tracker #(
    .MIN_EYE (MIN_EYE)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_clr),
    .eval       (w_eval),
    .pass       (r_ok),
    .tap        (r_tap),
    .last       (r_tap == TAP_MAX),
    .eye_center (w_center),
    .eye_width  (w_width),
    .eye_ok     (w_eye_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_tap        <= '0;
      r_ok         <= 1'b0;
      r_load       <= 1'b0;
      r_cnt_value  <= '0;
      r_en_vtc     <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_eye_center <= '0;
      r_eye_width  <= '0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_busy   <= 1'b1;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
            r_tap    <= '0;
            r_cnt    <= '0;
            r_en_vtc <= 1'b0;
            r_state  <= ST_VTC_OFF;
          end
        end
        ST_VTC_OFF: begin
          if (r_cnt == c_VTC_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          r_load      <= 1'b1;
          r_cnt_value <= r_tap;
          r_cnt       <= '0;
          r_state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt   <= '0;
            r_ok    <= 1'b1;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_ok <= r_ok && w_match;
          if (r_cnt == c_SAMPLE_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_EVAL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          if (r_tap != TAP_MAX) begin
            r_tap   <= r_tap + 1'b1;
            r_state <= ST_LOAD;
          end else begin
            r_state <= ST_CENTER;
          end
        end
        ST_CENTER: begin
          r_eye_center <= w_eye_ok ? w_center : '0;
          r_eye_width  <= w_width;
          r_cnt_value  <= w_eye_ok ? w_center : '0;
          r_load       <= 1'b1;
          r_locked     <= w_eye_ok;
          r_error      <= !w_eye_ok;
          r_state      <= ST_VTC_ON;
        end
        ST_VTC_ON: begin
          r_en_vtc <= 1'b1;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dly_load      = r_load;
  assign bus.dly_cnt_value = r_cnt_value;
  assign bus.dly_en_vtc    = r_en_vtc;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.locked        = r_locked;
  assign bus.error         = r_error;
  assign bus.eye_center    = r_eye_center;
  assign bus.eye_width     = r_eye_width;

endmodule
`default_nettype wire

// File: tb/tb_iddr_delay_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iddr_delay_cal : directed sweeps with a scoreboard of expected eyes     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iddr_delay_cal;

  localparam int W  = 2;
  localparam int VW = 4;
  localparam int S  = 2;
  localparam int M  = 4;
  localparam int ME = 8;
  localparam int N  = VW + 512 * (S + M + 2) + 2;

  typedef struct {
    int center;
    int width;
    int locked;
    int error;
    int load;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [511:0] pass_mask;
  int           glitch_tap;
  int           cur_tap;
  int           cyc;
  int           last_load;

  iddr_delay_cal_if #(.WIDTH(W)) bus ();

  iddr_delay_cal #(
    .WIDTH         (W),
    .VTC_WAIT      (VW),
    .SETTLE_CYCLES (S),
    .SAMPLE_CYCLES (M),
    .MIN_EYE       (ME)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Delay-line model: good pattern only inside the sample window of a passing tap
  initial begin
    cur_tap   = -1;
    cyc       = 0;
    last_load = -1;
    bus.q1    = '0;
    bus.q2    = '0;
    forever begin
      @(negedge clk);
      if (bus.dly_load === 1'b1) begin
        cur_tap   = int'(bus.dly_cnt_value);
        last_load = cur_tap;
        cyc       = 0;
      end else begin
        cyc++;
      end
      if (cur_tap >= 0 && cur_tap < 512 && pass_mask[cur_tap] && cyc >= S && cyc < S + M) begin
        bus.q1 = '1;
        bus.q2 = '0;
        if (cur_tap == glitch_tap && cyc == S + 1) bus.q1[1] = 1'b0;
      end else begin
        bus.q1 = '0;
        bus.q2 = '0;
      end
    end
  end

  task automatic set_mask(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pass_mask[i] = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en_vtc"}, bus.dly_en_vtc, 1);
    check({tag, "_load"}, bus.dly_load, 0);
    check({tag, "_cnt_value"}, bus.dly_cnt_value, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_locked"}, bus.locked, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_center"}, bus.eye_center, 0);
    check({tag, "_width"}, bus.eye_width, 0);
  endtask

  task automatic run_sweep(input string tag, input exp_t e, input bit extra);
    int   n;
    bit   seen;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_hi"}, bus.busy, 1);
    check({tag, "_vtc_lo"}, bus.dly_en_vtc, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < N + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (extra) bus.start = (n == 100 || n == 3000 || n == N - 1);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, N);
    got = sb.pop_front();
    check({tag, "_center"}, bus.eye_center, got.center);
    check({tag, "_width"}, bus.eye_width, got.width);
    check({tag, "_locked"}, bus.locked, got.locked);
    check({tag, "_error"}, bus.error, got.error);
    check({tag, "_final_load"}, last_load, got.load);
    check({tag, "_busy_lo"}, bus.busy, 0);
    check({tag, "_vtc_hi"}, bus.dly_en_vtc, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_locked_hold"}, bus.locked, got.locked);
  endtask

  initial begin
    bit reached;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    pass_mask  = '0;
    glitch_tap = -1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    pass_mask = '0; set_mask(0, 511);
    run_sweep("all_pass", '{256, 512, 1, 0, 256}, 1'b0);

    pass_mask = '0; set_mask(100, 199);
    run_sweep("mid_eye", '{150, 100, 1, 0, 150}, 1'b0);

    pass_mask = '0; set_mask(10, 39); set_mask(300, 349);
    run_sweep("two_runs", '{325, 50, 1, 0, 325}, 1'b0);

    pass_mask = '0; set_mask(10, 59); set_mask(300, 349);
    run_sweep("equal_runs", '{35, 50, 1, 0, 35}, 1'b0);

    pass_mask = '0; set_mask(400, 511);
    run_sweep("open_end", '{456, 112, 1, 0, 456}, 1'b0);

    pass_mask = '0; set_mask(0, 4);
    run_sweep("narrow", '{0, 5, 0, 1, 0}, 1'b0);

    pass_mask = '0; set_mask(150, 249); glitch_tap = 200;
    run_sweep("glitch", '{175, 50, 1, 0, 175}, 1'b0);
    glitch_tap = -1;

    // abort mid-sweep with an asynchronous reset
    pass_mask = '0; set_mask(0, 511);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < N && !reached; i++) begin
      @(negedge clk);
      #1;
      if (cur_tap == 300) reached = 1'b1;
    end
    check("mid_reached_tap300", reached, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep("after_rst", '{256, 512, 1, 0, 256}, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
